// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and bubble constant for pipeline stages
package pipe_pkg;
   // Encoding equals the number of held entries, so occupancy is the state register itself
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;
endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: handshake, payload, flush and statistics bundle of one pipeline stage
//   slave  : stage side (consumes in_*/out_ready_i/flush_i, drives the rest)
//   master : surrounding pipeline side
interface pipe_stage_skid_if #(
   parameter int INST_W = 32,
   parameter int PC_W   = 32,
   parameter int CNT_W  = 16
);
   logic              in_valid_i;
   logic              in_ready_o;
   logic [INST_W-1:0] inst_i;
   logic [PC_W-1:0]   pc_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [INST_W-1:0] inst_o;
   logic [PC_W-1:0]   pc_o;
   logic              flush_i;
   logic [1:0]        occupancy_o;
   logic [CNT_W-1:0]  stall_cnt_o;
   logic [CNT_W-1:0]  flush_cnt_o;
   modport slave (
      input  in_valid_i, inst_i, pc_i, out_ready_i, flush_i,
      output in_ready_o, out_valid_o, inst_o, pc_o, occupancy_o, stall_cnt_o, flush_cnt_o
   );
   modport master (
      output in_valid_i, inst_i, pc_i, out_ready_i, flush_i,
      input  in_ready_o, out_valid_o, inst_o, pc_o, occupancy_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: synchronous saturating up-counter
//   clk_i : clock
//   clr_i : synchronous clear, dominates inc_i
//   inc_i : add one unless already at all-ones
//   cnt_o : registered count
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
   always_ff @(posedge clk_i) cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with two-entry skid buffer, flush and stall/flush counters
//   clk_i   : clock, rising edge
//   rst_n_i : synchronous active-low reset (overrides flush)
//   bus     : pipe_stage_skid_if.slave -- valid/ready in and out, inst/pc payload,
//             flush, occupancy and saturating stall/flush counters
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                INST_W      = 32,
   parameter int                PC_W        = 32,
   parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(NOP_INST),
   parameter int                CNT_W       = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   pipe_stage_skid_if.slave     bus
);
   localparam int PAY_W = INST_W + PC_W;
   localparam logic [PAY_W-1:0] BUBBLE_PAY = {BUBBLE_INST, {PC_W{1'b0}}};
   state_e           state_q;
   logic [PAY_W-1:0] main_q, skid_q;
   logic             out_valid_q, in_ready_q;
   logic             in_fire, out_fire;
   logic [PAY_W-1:0] in_pay;
   assign in_pay   = {bus.inst_i, bus.pc_i};
   assign in_fire  = bus.in_valid_i & in_ready_q;
   assign out_fire = out_valid_q & bus.out_ready_i;
   // main_q is reloaded with the bubble whenever the stage empties, so the
   // payload outputs come straight from the register and are never stale
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || bus.flush_i) begin
         state_q     <= ST_EMPTY;
         main_q      <= BUBBLE_PAY;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: if (in_fire) begin
               state_q     <= ST_FULL;
               main_q      <= in_pay;
               out_valid_q <= 1'b1;
            end
            ST_FULL: begin
               if (in_fire && out_fire) main_q <= in_pay;
               else if (out_fire) begin
                  state_q     <= ST_EMPTY;
                  main_q      <= BUBBLE_PAY;
                  out_valid_q <= 1'b0;
               end else if (in_fire) begin
                  state_q    <= ST_SKID;
                  skid_q     <= in_pay;
                  in_ready_q <= 1'b0;
               end
            end
            ST_SKID: if (out_fire) begin
               state_q    <= ST_FULL;
               main_q     <= skid_q;
               in_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= ST_EMPTY;
               main_q      <= BUBBLE_PAY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end
   assign bus.in_ready_o  = in_ready_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.inst_o      = main_q[PAY_W-1:PC_W];
   assign bus.pc_o        = main_q[PC_W-1:0];
   assign bus.occupancy_o = state_q;
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .clr_i (~rst_n_i),
      .inc_i (out_valid_q & ~bus.out_ready_i),
      .cnt_o (bus.stall_cnt_o)
   );
   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .clr_i (~rst_n_i),
      .inc_i (bus.flush_i),
      .cnt_o (bus.flush_cnt_o)
   );
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised inter-stage pipeline register, the successor of the fixed 32-bit IF/ID latch. It carries a configurable instruction/PC payload between any two pipeline stages with a valid/ready handshake and a two-entry skid buffer, so back-pressure never needs a combinational ready path. Flush inserts a bubble, and saturating counters track stall and flush activity for performance debug. Instances sit at IF/ID, ID/EX and EX/MEM.

## Interface
- INST_W, 32, instruction payload width
- PC_W, 32, PC payload width
- BUBBLE_INST, {INST_W{1'b0}}, instruction value presented when the stage holds no valid entry
- CNT_W, 16, width of each statistics counter
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  synchronous, active-low reset
- in_valid_i  in  1  upstream holds a valid payload
- in_ready_o  out  1  stage accepts a payload this cycle
- inst_i  in  INST_W  upstream instruction
- pc_i  in  PC_W  upstream PC
- out_valid_o  out  1  stage presents a valid payload
- out_ready_i  in  1  downstream accepts the payload this cycle
- inst_o  out  INST_W  presented instruction
- pc_o  out  PC_W  presented PC
- flush_i  in  1  discard all held and incoming payloads
- occupancy_o  out  2  number of held entries (0, 1 or 2)
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating
- flush_cnt_o  out  CNT_W  cycles with flush_i=1, saturating

## Operation
- in_fire = in_valid_i & in_ready_o.
- out_fire = out_valid_o & out_ready_i.
- State machine states: EMPTY (0 entries), FULL (main register valid), SKID (main and skid registers valid).
- EMPTY:
  - in_fire -> FULL, main <= input.
  - Otherwise stays EMPTY.
- FULL:
  - in_fire and out_fire -> FULL, main <= input.
  - out_fire only -> EMPTY.
  - in_fire only -> SKID, skid <= input.
  - Neither -> FULL, hold.
- SKID:
  - in_ready_o=0, so no in_fire can occur.
  - out_fire -> FULL, main <= skid.
  - Otherwise hold.
- Ordering: payloads leave in arrival order; the skid entry is always younger than the main entry.
- flush_i=1 has highest priority:
  - Next state is EMPTY regardless of in_fire or out_fire.
  - An incoming payload in the same cycle is dropped.
  - A payload handed downstream in the same cycle (out_fire) is considered delivered; the consumer handles the flush itself.
- When out_valid_o=0, inst_o=BUBBLE_INST and pc_o=0. Outputs are never stale.
- occupancy_o: EMPTY=0, FULL=1, SKID=2.
- stall_cnt_o increments by 1 per stall cycle and saturates at 2^CNT_W-1.
- flush_cnt_o increments by 1 per flush cycle and saturates at 2^CNT_W-1.
- Reset (rst_n_i=0 at a clock edge):
  - State returns to EMPTY; skid and main registers are cleared.
  - out_valid_o=0, inst_o=BUBBLE_INST, pc_o=0, occupancy_o=0.
  - Both counters are cleared.
  - in_ready_o=1 from the first cycle after reset.
  - Reset mid-operation discards everything held, with the same result as power-up.
  - Reset overrides flush.

## Timing
- Latency: payload accepted at edge N is presented in the cycle after edge N (out_valid_o high after N). No same-cycle bypass.
- Throughput: one payload per cycle when out_ready_i is continuously high.
- in_ready_o is a registered function of state only (high in EMPTY and FULL). There is no combinational path from out_ready_i to in_ready_o.
- out_valid_o, inst_o, pc_o and occupancy_o are driven directly from registers.
- Counters update on the edge that samples the qualifying condition.
- Handshake rules:
  - Upstream keeps inst_i/pc_i stable while in_valid_i=1 and in_ready_o=0.
  - The stage keeps its outputs stable while out_valid_o=1 and out_ready_i=0, unless flushed.

## Structure
- Shared package `pipe_pkg` holds the state enum (ST_EMPTY, ST_FULL, ST_SKID) and the default NOP constant used for BUBBLE_INST.
- One sub-module is natural: `sat_counter` (CNT_W parameter, inc and clear inputs), instantiated twice for the stall and flush counters.
- Payload registers are a single packed {inst, pc} vector of INST_W+PC_W bits for the main and skid entries.

## Test plan
- Reset, then stream pc=0x00,0x04,0x08 with out_ready_i=1 -> outputs appear one cycle later in order; occupancy_o=1; in_ready_o stays 1; stall_cnt_o=0.
- With out_ready_i=0, send pc=0x10 then pc=0x14 -> occupancy_o=2 and in_ready_o=0. Raise out_ready_i -> 0x10 then 0x14 are delivered; stall_cnt_o equals the number of held cycles.
- In SKID state assert flush_i with in_valid_i=1 -> next cycle out_valid_o=0, inst_o=BUBBLE_INST, pc_o=0, occupancy_o=0, flush_cnt_o=1; the incoming payload never appears.
- With CNT_W=4, hold out_ready_i=0 with a valid entry for 20 cycles -> stall_cnt_o saturates at 15 and does not wrap.
- Pull rst_n_i low while in SKID with both counters nonzero -> after the edge, all outputs at reset values and counters at 0. Assert flush_i together with rst_n_i=0 -> flush_cnt_o remains 0.
